// File: rtl/dcache_wt_ctrl_if.sv
// Main-memory request/ready bus between the data cache controller and a
// multi-cycle memory; the controller is the master.
interface dcache_wt_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// one-word lines, fronting a req/ready main memory for a single-cycle core.
module dcache_wt_ctrl #(
  parameter int unsigned NUM_LINES = 64,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  dcache_wt_ctrl_if.master  mem
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

  state_t state, next_state;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_store  [NUM_LINES];
  logic [DATA_W-1:0]    data_store [NUM_LINES];

  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             fill_en;
  logic             upd_en;
  logic             load_idle;

  assign index = addr[IDX_W+1:2];
  assign tag   = addr[ADDR_W-1:IDX_W+2];
  assign hit   = valid[index] && (tag_store[index] == tag);

  // Request fields come straight from the core inputs, which the core holds
  // constant while stalled, so they stay stable for the whole handshake.
  assign mem.mem_addr  = addr & ~ADDR_W'(3);
  assign mem.mem_wdata = write_data;

  assign fill_en   = (state == RD_MISS) && mem.mem_ready;
  assign upd_en    = (state == WR_THRU) && mem.mem_ready && hit;
  assign load_idle = (state == IDLE) && mem_read && !mem_write;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    stall       = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    read_data   = data_store[index];
    unique case (state)
      IDLE: begin
        if (mem_write) begin
          stall      = 1'b1;
          next_state = WR_THRU;
        end else if (mem_read && !hit) begin
          stall      = 1'b1;
          next_state = RD_MISS;
        end
      end
      RD_MISS: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ready) next_state = DONE;
      end
      WR_THRU: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        if (mem.mem_ready) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset overrides everything, abandoning any outstanding request at once.
    if (!reset_n) begin
      stall       = 1'b0;
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      read_data   = '0;
      next_state  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (reset_n && fill_en) begin
      tag_store[index]  <= tag;
      data_store[index] <= mem.mem_rdata;
    end else if (reset_n && upd_en) begin
      data_store[index] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (load_idle) begin
      if (hit && (hit_count != '1)) hit_count <= hit_count + 32'd1;
      if (!hit && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: doc/dcache_wt_ctrl.md
Name: dcache_wt_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller. Sits directly downstream of the single-cycle core's datapath/control.
- Consumes the core's MemRead, MemWrite, ALUResult (address) and WriteData.
- Returns read data (the core's Result input) and stall; stall freezes the PC and register writes.
- Fronts a multi-cycle main memory through a req/ready handshake.

Parameters:
NUM_LINES, 64, number of one-word cache lines; power of 2, at least 2; IDX_W = log2(NUM_LINES)
DATA_W, 32, word width; fixed at 32
ADDR_W, 32, byte address width; tag width TAG_W = ADDR_W - 2 - IDX_W

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
mem_read  in  1  core load request (MemRead)
mem_write  in  1  core store request (MemWrite)
addr  in  32  byte address (ALUResult); bits [1:0] ignored
write_data  in  32  store data (WriteData)
read_data  out  32  load data to core (Result)
stall  out  1  core must hold its state this cycle
mem_req  out  1  main-memory request
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  32  word-aligned memory address, {addr[31:2],2'b00}
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data; valid with mem_ready
mem_ready  in  1  memory completes current request this cycle
hit_count  out  32  load hits, saturating
miss_count  out  32  load misses, saturating

Behaviour:
- Address split: index = addr[2+IDX_W-1:2], tag = addr[31:2+IDX_W]. Storage per line: valid bit, tag, data word. Array read is combinational; array write occurs on the clock edge.
- hit = valid[index] && tag_store[index] == tag. The hit is evaluated on the live core address.
- FSM states: IDLE, RD_MISS, WR_THRU, DONE.
- IDLE:
  - mem_write=1 (priority, including when mem_read=1 too): stall=1 combinationally; next state WR_THRU.
  - mem_read=1 and hit: stall=0; read_data = data[index]; hit_count++ at the edge; stay in IDLE.
  - mem_read=1 and miss: stall=1 combinationally; miss_count++; next state RD_MISS.
  - Neither request: stall=0; read_data = data[index] (don't-care value); stay in IDLE.
- RD_MISS: stall=1, mem_req=1, mem_we=0, mem_addr from addr.
  - On mem_ready=1: valid[index]<=1, tag_store[index]<=tag, data[index]<=mem_rdata; next state DONE.
- WR_THRU: stall=1, mem_req=1, mem_we=1, mem_wdata=write_data.
  - On mem_ready=1: if hit, data[index]<=write_data. If miss, the cache is unchanged (no allocate). Next state DONE.
- DONE: stall=0, mem_req=0, read_data = data[index] (now the filled or updated word). The core advances at this edge; next state IDLE unconditionally.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata are stable from state entry until the cycle mem_ready is sampled high.
  - mem_ready is ignored outside RD_MISS/WR_THRU.
  - mem_ready may be high in the first cycle of the state, giving a minimum of 1 wait cycle.
  - Minimum miss/store penalty: 2 stalled cycles plus a DONE cycle.
- Core holds mem_read, mem_write, addr and write_data constant while stall=1. The controller is not required to handle changes during a stall.
- Counters saturate at 32'hFFFF_FFFF. Stores are not counted.
- Reset (reset_n=0 at an edge), including mid-transaction:
  - state<=IDLE, all valid bits<=0, hit_count<=0, miss_count<=0.
  - Any outstanding memory request is abandoned; mem_req is 0 from the next cycle.
- While reset_n=0: stall=0, mem_req=0, mem_we=0, read_data=0.
- Tag and data arrays are not reset.

Test Plan:
- Reset, then load 0x100; memory drives mem_ready on the 3rd request cycle with 0xDEADBEEF -> stall=1 from the first cycle; mem_req=1, mem_we=0, mem_addr=0x100 for 3 cycles; DONE cycle has stall=0 and read_data=0xDEADBEEF; miss_count=1.
- Load 0x100 again -> stall=0 in the same cycle, read_data=0xDEADBEEF, mem_req stays 0, hit_count=1.
- Store 0x12345678 to 0x100 (hit), then load 0x100 -> mem_req=1, mem_we=1, mem_wdata=0x12345678 until ready; the following load hits and returns 0x12345678.
- Store 0xCAFE0000 to 0x204 (miss), then load 0x204 -> the store goes to memory only; the load misses (miss_count increments) and refills from memory.
- Conflict: load 0x200 (index 0, tag 2) after 0x100 (index 0, tag 1) is cached -> miss and eviction; a following load of 0x100 misses again; miss_count increments twice.
- Assert reset_n=0 for 1 cycle during RD_MISS for 0x100 -> mem_req=0 the next cycle, counters=0; a reload of 0x100 misses. Also drive mem_read=mem_write=1 -> the access is handled as a write (mem_we=1).
